// File: rtl/life_engine.sv
// life_engine: 8x8 toroidal Conway's Life (B3/S23) engine with keypad presets.
// A new preset is loaded whenever the selector code differs from the last
// loaded code. Generations advance either from a free-running divider (run=1)
// or from single-cycle step strobes while paused (run=0).
module life_engine #(
    parameter int unsigned STEP_DIV = 32'd25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pattern,
    input  logic        run,
    input  logic        step,
    output logic [63:0] grid,
    output logic [7:0]  gen,
    output logic        alive
);

    logic [3:0]  pat_q;
    logic [31:0] divider;
    logic        load_s;
    logic        tick_s;
    logic        advance_s;
    logic [63:0] next_grid_s;

    // Preset table: one byte per row, bit c of each byte is column c.
    function automatic logic [63:0] preset(input logic [3:0] code);
        logic [63:0] p;
        p = 64'd0;
        case (code)
            4'd1:    p = 64'h0000_0000_0E08_0400; // glider
            4'd2:    p = 64'h0000_0000_1C00_0000; // blinker
            4'd3:    p = 64'h0000_0018_1800_0000; // block
            4'd4:    p = 64'h0000_000E_1C00_0000; // toad
            4'd5:    p = 64'h0000_0018_1002_0600; // beacon
            default: p = 64'd0;                   // clear
        endcase
        return p;
    endfunction

    // One B3/S23 generation on a torus. The 3x3 window sum includes the
    // cell itself, so the centre is subtracted to get the neighbour count.
    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] nx;
        logic [3:0]  n;
        logic [2:0]  rr;
        logic [2:0]  cc;
        logic [5:0]  idx;
        nx = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                idx = {3'(r), 3'(c)};
                n   = 4'd0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = 3'(r + dr);
                        cc = 3'(c + dc);
                        n  = n + {3'd0, g[{rr, cc}]};
                    end
                end
                n = n - {3'd0, g[idx]};
                nx[idx] = (n == 4'd3) || (g[idx] && (n == 4'd2));
            end
        end
        return nx;
    endfunction

    // Decode load request, divider terminal count and generation request.
    always_comb begin
        load_s      = (pattern != pat_q);
        tick_s      = run && (divider == 32'(STEP_DIV - 32'd1));
        advance_s   = run ? tick_s : step;
        next_grid_s = life_step(grid);
    end

    // State update: load beats generation; paused mode holds the divider at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid    <= 64'd0;
            gen     <= 8'd0;
            pat_q   <= 4'd0;
            divider <= 32'd0;
        end else if (load_s) begin
            grid    <= preset(pattern);
            pat_q   <= pattern;
            gen     <= 8'd0;
            divider <= 32'd0;
        end else begin
            if (run) begin
                divider <= tick_s ? 32'd0 : divider + 32'd1;
            end else begin
                divider <= 32'd0;
            end
            if (advance_s) begin
                grid <= next_grid_s;
                gen  <= gen + 8'd1;
            end else begin
                grid <= grid;
                gen  <= gen;
            end
        end
    end

    // Any live cell, taken straight from the grid register.
    assign alive = |grid;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine with STEP_DIV=4, using a cell-array
// reference model of the Life rules, presets and generation timing.
module tb_life_engine;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  pattern = 4'd0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [63:0] grid;
    logic [7:0]  gen;
    logic        alive;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [63:0] m_grid = 64'd0;
    int          m_gen = 0;
    int          m_pat = 0;
    int          m_cnt = 0;

    life_engine #(.STEP_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .pattern(pattern), .run(run), .step(step),
        .grid(grid), .gen(gen), .alive(alive)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m_preset(input int code);
        logic [7:0] rows [8];
        logic [63:0] g;
        for (int i = 0; i < 8; i++) rows[i] = 8'h00;
        case (code)
            1: begin rows[1] = 8'h04; rows[2] = 8'h08; rows[3] = 8'h0E; end
            2: begin rows[3] = 8'h1C; end
            3: begin rows[3] = 8'h18; rows[4] = 8'h18; end
            4: begin rows[3] = 8'h1C; rows[4] = 8'h0E; end
            5: begin rows[1] = 8'h06; rows[2] = 8'h02; rows[3] = 8'h10; rows[4] = 8'h18; end
            default: ;
        endcase
        g = 64'd0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                g[8*r+c] = rows[r][c];
        return g;
    endfunction

    function automatic logic [63:0] m_evolve(input logic [63:0] g);
        logic [63:0] nx;
        int n;
        nx = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(g[8*((r+dr+8)%8) + ((c+dc+8)%8)]);
                nx[8*r+c] = (n == 3) || (g[8*r+c] && n == 2);
            end
        end
        return nx;
    endfunction

    function automatic void m_generation();
        m_grid = m_evolve(m_grid);
        m_gen  = (m_gen + 1) % 256;
    endfunction

    // Advance one rising edge and apply the same edge to the model, then
    // settle 1 time unit so outputs can be sampled away from the edge.
    task automatic clk_edge();
        @(posedge clk);
        if (!rst) begin
            m_grid = 64'd0; m_gen = 0; m_pat = 0; m_cnt = 0;
        end else if (int'(pattern) != m_pat) begin
            m_grid = m_preset(int'(pattern));
            m_pat  = int'(pattern);
            m_gen  = 0;
            m_cnt  = 0;
        end else if (run) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_generation();
            end
        end else begin
            m_cnt = 0;
            if (step) m_generation();
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pattern = 4'd3; run = 1'b1; step = 1'b1;
        repeat (3) clk_edge();
        vectors++;
        if ({grid, gen, alive} !== {64'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: got grid=%h gen=%0d alive=%b, want 0/0/0", grid, gen, alive);
        end
        pattern = 4'd0; run = 1'b0; step = 1'b0;
        clk_edge();
        rst = 1'b1;
        repeat (3) clk_edge();
        vectors++;
        if ({grid, gen, alive} !== {64'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release_p0: got grid=%h gen=%0d alive=%b, want 0/0/0", grid, gen, alive);
        end
    endtask

    task automatic test_blinker();
        pattern = 4'd2; run = 1'b0; step = 1'b0;
        clk_edge();
        vectors++;
        if ({grid, gen, alive} !== {64'h0000_0000_1C00_0000, 8'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL blinker_load: got grid=%h gen=%0d alive=%b, want %h 0 1", grid, gen, alive, 64'h0000_0000_1C00_0000);
        end
        step = 1'b1; clk_edge(); step = 1'b0;
        vectors++;
        if ({grid, gen} !== {64'h0000_0008_0808_0000, 8'd1}) begin
            miscompares++;
            $display("FAIL blinker_step1: got grid=%h gen=%0d, want %h 1", grid, gen, 64'h0000_0008_0808_0000);
        end
        repeat (2) clk_edge();
        vectors++;
        if (gen !== 8'd1) begin
            miscompares++;
            $display("FAIL blinker_idle: got gen=%0d, want 1", gen);
        end
        step = 1'b1; clk_edge(); step = 1'b0;
        vectors++;
        if ({grid, gen} !== {64'h0000_0000_1C00_0000, 8'd2}) begin
            miscompares++;
            $display("FAIL blinker_step2: got grid=%h gen=%0d, want %h 2", grid, gen, 64'h0000_0000_1C00_0000);
        end
    endtask

    task automatic test_block_run();
        pattern = 4'd3; run = 1'b1; step = 1'b0;
        clk_edge();
        for (int i = 1; i <= 40; i++) begin
            clk_edge();
            vectors++;
            if ({grid, gen, alive} !== {m_grid, 8'(m_gen), |m_grid}) begin
                miscompares++;
                $display("FAIL block_run cyc%0d: got grid=%h gen=%0d, want grid=%h gen=%0d", i, grid, gen, m_grid, m_gen);
            end
            vectors++;
            if (gen !== 8'(i / DIV)) begin
                miscompares++;
                $display("FAIL block_cadence cyc%0d: got gen=%0d, want %0d", i, gen, i / DIV);
            end
        end
        vectors++;
        if ({grid, gen} !== {64'h0000_0018_1800_0000, 8'd10}) begin
            miscompares++;
            $display("FAIL block_final: got grid=%h gen=%0d, want %h 10", grid, gen, 64'h0000_0018_1800_0000);
        end
        run = 1'b0;
    endtask

    task automatic test_glider();
        pattern = 4'd1; run = 1'b0; step = 1'b0;
        clk_edge();
        step = 1'b1;
        repeat (4) clk_edge();
        vectors++;
        if ({grid, gen} !== {64'h0000_001C_1008_0000, 8'd4}) begin
            miscompares++;
            $display("FAIL glider_4: got grid=%h gen=%0d, want %h 4", grid, gen, 64'h0000_001C_1008_0000);
        end
        for (int i = 5; i <= 32; i++) begin
            clk_edge();
            vectors++;
            if ({grid, gen} !== {m_grid, 8'(m_gen)}) begin
                miscompares++;
                $display("FAIL glider_model step%0d: got grid=%h gen=%0d, want grid=%h gen=%0d", i, grid, gen, m_grid, m_gen);
            end
        end
        step = 1'b0;
        vectors++;
        if ({grid, gen} !== {64'h0000_0000_0E08_0400, 8'd32}) begin
            miscompares++;
            $display("FAIL glider_32: got grid=%h gen=%0d, want %h 32", grid, gen, 64'h0000_0000_0E08_0400);
        end
    endtask

    task automatic test_load_priority();
        pattern = 4'd2; run = 1'b1; step = 1'b0;
        clk_edge();
        repeat (DIV - 1) clk_edge();
        vectors++;
        if (gen !== 8'd0) begin
            miscompares++;
            $display("FAIL prio_pre: got gen=%0d, want 0", gen);
        end
        pattern = 4'd5;
        clk_edge();
        vectors++;
        if ({grid, gen} !== {64'h0000_0018_1002_0600, 8'd0}) begin
            miscompares++;
            $display("FAIL prio_load: got grid=%h gen=%0d, want %h 0", grid, gen, 64'h0000_0018_1002_0600);
        end
        pattern = 4'd3; run = 1'b0;
        clk_edge();
        step = 1'b1;
        repeat (255) clk_edge();
        vectors++;
        if (gen !== 8'd255) begin
            miscompares++;
            $display("FAIL gen_255: got gen=%0d, want 255", gen);
        end
        clk_edge();
        step = 1'b0;
        vectors++;
        if ({grid, gen} !== {64'h0000_0018_1800_0000, 8'd0}) begin
            miscompares++;
            $display("FAIL gen_wrap: got grid=%h gen=%0d, want %h 0", grid, gen, 64'h0000_0018_1800_0000);
        end
    endtask

    task automatic test_async_reset();
        pattern = 4'd4; run = 1'b1; step = 1'b0;
        clk_edge();
        repeat (6) clk_edge();
        vectors++;
        if ({grid, gen} !== {m_grid, 8'(m_gen)}) begin
            miscompares++;
            $display("FAIL toad_run: got grid=%h gen=%0d, want grid=%h gen=%0d", grid, gen, m_grid, m_gen);
        end
        #2 rst = 1'b0;
        m_grid = 64'd0; m_gen = 0; m_pat = 0; m_cnt = 0;
        #1;
        vectors++;
        if ({grid, gen, alive} !== {64'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got grid=%h gen=%0d alive=%b, want 0/0/0", grid, gen, alive);
        end
        repeat (2) clk_edge();
        rst = 1'b1;
        clk_edge();
        vectors++;
        if ({grid, gen} !== {64'h0000_000E_1C00_0000, 8'd0}) begin
            miscompares++;
            $display("FAIL toad_reload: got grid=%h gen=%0d, want %h 0", grid, gen, 64'h0000_000E_1C00_0000);
        end
    endtask

    task automatic test_clear_run();
        pattern = 4'd0; run = 1'b1;
        clk_edge();
        for (int i = 1; i <= 20; i++) begin
            step = 1'($urandom_range(0, 1));
            clk_edge();
            vectors++;
            if ({grid, gen, alive} !== {64'd0, 8'(i / DIV), 1'b0}) begin
                miscompares++;
                $display("FAIL clear_run cyc%0d: got grid=%h gen=%0d alive=%b, want 0 %0d 0", i, grid, gen, alive, i / DIV);
            end
        end
        step = 1'b0; run = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) pattern = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) run = ~run;
            step = 1'($urandom_range(0, 2) == 0);
            clk_edge();
            vectors++;
            if ({grid, gen, alive} !== {m_grid, 8'(m_gen), |m_grid}) begin
                miscompares++;
                $display("FAIL random cyc%0d: got grid=%h gen=%0d alive=%b, want grid=%h gen=%0d", i, grid, gen, alive, m_grid, m_gen);
            end
        end
        run = 1'b0; step = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_blinker();
        test_block_run();
        test_glider();
        test_load_priority();
        test_async_reset();
        test_clear_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
